// File: rtl/vga_frame_display.sv
// vga_frame_display: 640x480@60 VGA timing generator that reads an 80x60
// RGB444 frame buffer (1-cycle read latency) and shows each stored pixel
// as an 8x8 block. Two pipeline stages keep RGB, syncs and frame_start
// aligned with the buffer read data.
module vga_frame_display #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_nb_img_pxls = 13,
  parameter int c_scale_log2  = 3,
  parameter int c_nb_buf      = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [c_nb_buf-1:0]      frame_pxl,
  output logic [c_nb_img_pxls-1:0] frame_addr,
  output logic [3:0]               vga_red,
  output logic [3:0]               vga_green,
  output logic [3:0]               vga_blue,
  output logic                     vga_hsync,
  output logic                     vga_vsync,
  output logic                     frame_start
);

  localparam logic [9:0] H_VIS      = 10'd640;
  localparam logic [9:0] H_SYNC_BEG = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd751;
  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] V_VIS      = 10'd480;
  localparam logic [9:0] V_SYNC_BEG = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd491;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] IMG_COLS   = 10'(c_img_cols);
  localparam logic [9:0] IMG_ROWS   = 10'(c_img_rows);

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;

  // stage 0 (combinational)
  logic [9:0]               col, row;
  logic [c_nb_img_pxls-1:0] col_w, row_w;
  logic                     in_img_s0, hsync_s0, vsync_s0, first_s0;
  logic [c_nb_img_pxls-1:0] addr_s0;

  // stage 1
  logic in_img_s1_q, in_img_s1_d;
  logic hsync_s1_q, hsync_s1_d;
  logic vsync_s1_q, vsync_s1_d;
  logic first_s1_q, first_s1_d;

  // stage 2 (output registers)
  logic [c_nb_buf-1:0] rgb_q, rgb_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                frame_start_q, frame_start_d;

  // Raster counters: horizontal wraps at 799, vertical steps on that wrap.
  always_comb begin
    cnt_h_d = cnt_h_q + 10'd1;
    cnt_v_d = cnt_v_q;
    if (cnt_h_q == H_LAST) begin
      cnt_h_d = '0;
      cnt_v_d = (cnt_v_q == V_LAST) ? 10'd0 : cnt_v_q + 10'd1;
    end
  end

  // Stage 0: map screen position to image pixel and buffer address.
  // Multiply by 80 is done as two shifts and an add.
  always_comb begin
    col       = cnt_h_q >> c_scale_log2;
    row       = cnt_v_q >> c_scale_log2;
    col_w     = c_nb_img_pxls'(col);
    row_w     = c_nb_img_pxls'(row);
    in_img_s0 = (cnt_h_q < H_VIS) && (cnt_v_q < V_VIS) &&
                (col < IMG_COLS) && (row < IMG_ROWS);
    addr_s0   = in_img_s0 ? (row_w << 6) + (row_w << 4) + col_w : '0;
    hsync_s0  = !((cnt_h_q >= H_SYNC_BEG) && (cnt_h_q <= H_SYNC_END));
    vsync_s0  = !((cnt_v_q >= V_SYNC_BEG) && (cnt_v_q <= V_SYNC_END));
    first_s0  = (cnt_h_q == 10'd0) && (cnt_v_q == 10'd0);
  end

  assign frame_addr = addr_s0;

  // Stage 1/2 next-state: stage 1 delays control to meet the RAM data,
  // stage 2 blanks RGB outside the image and registers everything out.
  always_comb begin
    in_img_s1_d   = in_img_s0;
    hsync_s1_d    = hsync_s0;
    vsync_s1_d    = vsync_s0;
    first_s1_d    = first_s0;
    rgb_d         = in_img_s1_q ? frame_pxl : '0;
    hsync_d       = hsync_s1_q;
    vsync_d       = vsync_s1_q;
    frame_start_d = first_s1_q;
  end

  // All state; reset puts syncs idle-high and everything else to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_h_q       <= '0;
      cnt_v_q       <= '0;
      in_img_s1_q   <= 1'b0;
      hsync_s1_q    <= 1'b1;
      vsync_s1_q    <= 1'b1;
      first_s1_q    <= 1'b0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      in_img_s1_q   <= in_img_s1_d;
      hsync_s1_q    <= hsync_s1_d;
      vsync_s1_q    <= vsync_s1_d;
      first_s1_q    <= first_s1_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_red     = rgb_q[11:8];
  assign vga_green   = rgb_q[7:4];
  assign vga_blue    = rgb_q[3:0];
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign frame_start = frame_start_q;

endmodule
